bandit_arbiter: RTL and testbench

- Shares one bandit agent (8-bit action stream out, 8-bit reward stream in) among N environment requesters.
- Grants the agent to one environment per episode, round-robin. An episode is one action transfer followed by exactly one reward transfer.
- Guarantees each reward reaching the bandit belongs to the action just issued.
- Sits between the bandit core and the environment front-ends.

---
 rtl/bandit_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_bandit_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bandit_arbiter.sv
// Round-robin arbiter that lends one bandit agent to N environments, one action/reward episode at a time.
// Optional reward-wait timeout with injected reward: define BANDIT_ARBITER_TIMEOUT_EN.
module bandit_arbiter #(
  parameter int unsigned N              = 4,
  parameter int unsigned COUNT_WIDTH    = 16,
  parameter int unsigned TIMEOUT        = 255,
  parameter logic [7:0]  TIMEOUT_REWARD = 8'h00
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N-1:0]           env_request,
  output logic [N-1:0]           env_action_valid,
  output logic [7:0]             env_action_data,
  input  logic [N-1:0]           env_action_ready,
  input  logic [N-1:0]           env_reward_valid,
  input  logic [8*N-1:0]         env_reward_data,
  output logic [N-1:0]           env_reward_ready,
  input  logic                   action_valid,
  input  logic [7:0]             action_data,
  output logic                   action_ready,
  output logic                   reward_valid,
  output logic [7:0]             reward_data,
  input  logic                   reward_ready,
  output logic [N-1:0]           grant,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] episode_count
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTION = 2'd1;
  localparam logic [1:0] S_REWARD = 2'd2;
`ifdef BANDIT_ARBITER_TIMEOUT_EN
  localparam logic [1:0] S_FLUSH  = 2'd3;
  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [WW-1:0] wait_q, wait_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(TIMEOUT), TIMEOUT_REWARD};
`endif

  logic [1:0]             state_q, state_d;
  logic [N-1:0]           grant_q, grant_d;
  logic [PW-1:0]          gidx_q, gidx_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic [PW-1:0] cand;
  logic [PW-1:0] pick_idx;
  logic          pick_found;
  logic [PW-1:0] ptr_next;

  // First requester at or above the pointer, wrapping modulo N.
  always_comb begin
    cand       = '0;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = PW'((32'(ptr_q) + k) % N);
      if (!pick_found && env_request[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign ptr_next = (gidx_q == PW'(N - 1)) ? '0 : gidx_q + PW'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      count_q <= '0;
`ifdef BANDIT_ARBITER_TIMEOUT_EN
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
`ifdef BANDIT_ARBITER_TIMEOUT_EN
      wait_q  <= wait_d;
`endif
    end
  end

  // Episode sequencing: grant, one action, one reward (or injected reward), release.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    count_d = count_q;
`ifdef BANDIT_ARBITER_TIMEOUT_EN
    wait_d  = wait_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d = S_ACTION;
          grant_d = N'(1) << pick_idx;
          gidx_d  = pick_idx;
        end
      end
      S_ACTION: begin
        if (action_valid && env_action_ready[gidx_q]) begin
          state_d = S_REWARD;
`ifdef BANDIT_ARBITER_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      S_REWARD: begin
        if (env_reward_valid[gidx_q] && reward_ready) begin
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = ptr_next;
          count_d = count_q + COUNT_WIDTH'(1);
        end
`ifdef BANDIT_ARBITER_TIMEOUT_EN
        else if (wait_q == WW'(TIMEOUT - 1)) begin
          state_d = S_FLUSH;
        end else begin
          wait_d = wait_q + WW'(1);
        end
`endif
      end
`ifdef BANDIT_ARBITER_TIMEOUT_EN
      S_FLUSH: begin
        if (reward_ready) begin
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = ptr_next;
          count_d = count_q + COUNT_WIDTH'(1);
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Stream routing is purely combinational through the registered grant.
  always_comb begin
    env_action_valid = '0;
    env_action_data  = action_data;
    env_reward_ready = '0;
    action_ready     = 1'b0;
    reward_valid     = 1'b0;
    reward_data      = '0;
    case (state_q)
      S_ACTION: begin
        env_action_valid = grant_q & {N{action_valid}};
        action_ready     = env_action_ready[gidx_q];
      end
      S_REWARD: begin
        reward_valid     = env_reward_valid[gidx_q];
        reward_data      = env_reward_data[{gidx_q, 3'b000} +: 8];
        env_reward_ready = grant_q & {N{reward_ready}};
      end
`ifdef BANDIT_ARBITER_TIMEOUT_EN
      S_FLUSH: begin
        reward_valid = 1'b1;
        reward_data  = TIMEOUT_REWARD;
      end
`endif
      default: ;
    endcase
  end

  assign grant         = grant_q;
  assign busy          = (state_q != S_IDLE);
  assign episode_count = count_q;

endmodule

// File: tb/tb_bandit_arbiter.sv
// Directed bench for bandit_arbiter: routing, round-robin order, reward isolation, stalls, reset, optional timeout.
module tb_bandit_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 16;

  logic           clock;
  logic           reset;
  logic [N-1:0]   env_request;
  logic [N-1:0]   env_action_valid;
  logic [7:0]     env_action_data;
  logic [N-1:0]   env_action_ready;
  logic [N-1:0]   env_reward_valid;
  logic [8*N-1:0] env_reward_data;
  logic [N-1:0]   env_reward_ready;
  logic           action_valid;
  logic [7:0]     action_data;
  logic           action_ready;
  logic           reward_valid;
  logic [7:0]     reward_data;
  logic           reward_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic [CW-1:0]  episode_count;

  int n_checks;
  int n_errors;

  bandit_arbiter #(
    .N(N), .COUNT_WIDTH(CW), .TIMEOUT(5), .TIMEOUT_REWARD(8'h00)
  ) dut (
    .clock(clock), .reset(reset),
    .env_request(env_request),
    .env_action_valid(env_action_valid), .env_action_data(env_action_data),
    .env_action_ready(env_action_ready),
    .env_reward_valid(env_reward_valid), .env_reward_data(env_reward_data),
    .env_reward_ready(env_reward_ready),
    .action_valid(action_valid), .action_data(action_data), .action_ready(action_ready),
    .reward_valid(reward_valid), .reward_data(reward_data), .reward_ready(reward_ready),
    .grant(grant), .busy(busy), .episode_count(episode_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    env_request      = '0;
    env_action_ready = '0;
    env_reward_valid = '0;
    env_reward_data  = '0;
    action_valid     = 1'b0;
    action_data      = '0;
    reward_ready     = 1'b0;
  endtask

  task automatic wait_busy(input int budget);
    for (int i = 0; i < budget && !busy; i++) step();
    check("wait_busy", 32'(busy), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    step();
    step();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(episode_count), 32'd0);
    check("rst_act_ready", 32'(action_ready), 32'd0);
    check("rst_rew_valid", 32'(reward_valid), 32'd0);
    check("rst_env_act_valid", 32'(env_action_valid), 32'd0);
    check("rst_env_rew_ready", 32'(env_reward_ready), 32'd0);
    reset = 1'b1;
    step();
  endtask

  // Full episode for the env expected to win; all envs offer rewards, only g's value is correct.
  task automatic episode(input int g, input logic [7:0] act, input logic [7:0] rew);
    wait_busy(10);
    check("ep_grant", 32'(grant), 32'(1) << g);
    action_valid     = 1'b1;
    action_data      = act;
    env_action_ready = '1;
    #1;
    check("ep_env_act_valid", 32'(env_action_valid), 32'(1) << g);
    check("ep_env_act_data", 32'(env_action_data), 32'(act));
    check("ep_act_ready", 32'(action_ready), 32'd1);
    step();
    action_valid     = 1'b0;
    env_action_ready = '0;
    env_reward_valid = '1;
    for (int k = 0; k < N; k++) env_reward_data[8*k +: 8] = (k == g) ? rew : ~rew;
    reward_ready = 1'b1;
    #1;
    check("ep_rew_valid", 32'(reward_valid), 32'd1);
    check("ep_rew_data", 32'(reward_data), 32'(rew));
    check("ep_env_rew_ready", 32'(env_reward_ready), 32'(1) << g);
    step();
    env_reward_valid = '0;
    reward_ready     = 1'b0;
    check("ep_idle_busy", 32'(busy), 32'd0);
    check("ep_idle_grant", 32'(grant), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    clear_inputs();
    do_reset();

    // Single episode for env0.
    env_request = 4'b0001;
    episode(0, 8'h2A, 8'h10);
    env_request = '0;
    check("single_count", 32'(episode_count), 32'd1);

    // All requesting: strict rotation from pointer 0.
    do_reset();
    env_request = 4'b1111;
    for (int i = 0; i < 8; i++) episode(i % 4, 8'(8'h30 + i), 8'(8'hA0 + i));
    env_request = 4'b0110;
    check("rr_count", 32'(episode_count), 32'd8);

    // Env2 offers a reward early while env1 owns the agent.
    wait_busy(10);
    check("iso_grant1", 32'(grant), 32'b0010);
    env_reward_valid = 4'b0100;
    env_reward_data[8*2 +: 8] = 8'h66;
    reward_ready = 1'b1;
    #1;
    check("iso_act_rew_ready", 32'(env_reward_ready), 32'd0);
    check("iso_act_rew_valid", 32'(reward_valid), 32'd0);
    action_valid = 1'b1;
    env_action_ready = 4'b0010;
    step();
    action_valid = 1'b0;
    env_action_ready = '0;
    env_reward_valid = 4'b0110;
    env_reward_data[8*1 +: 8] = 8'h55;
    env_request = 4'b0100;
    #1;
    check("iso_rew1_data", 32'(reward_data), 32'h55);
    check("iso_rew1_ready", 32'(env_reward_ready), 32'b0010);
    step();
    check("iso_idle_rew_ready", 32'(env_reward_ready), 32'd0);
    check("iso_idle_rew_valid", 32'(reward_valid), 32'd0);
    step();
    check("iso_grant2", 32'(grant), 32'b0100);
    check("iso_pre_act_rew_valid", 32'(reward_valid), 32'd0);
    check("iso_pre_act_rew_ready", 32'(env_reward_ready), 32'd0);
    action_valid = 1'b1;
    env_action_ready = 4'b0100;
    step();
    action_valid = 1'b0;
    env_action_ready = '0;
    env_request = '0;
    check("iso_rew2_data", 32'(reward_data), 32'h66);
    check("iso_rew2_ready", 32'(env_reward_ready), 32'b0100);
    step();
    env_reward_valid = '0;
    reward_ready = 1'b0;
    check("iso_count", 32'(episode_count), 32'd10);

    // Bandit stalls 20 cycles in ACTION; pointer is 3 so env0 wins by wrap.
    env_request = 4'b0001;
    wait_busy(10);
    env_reward_valid = '1;
    env_reward_data[7:0] = 8'h77;
    reward_ready = 1'b1;
    env_action_ready = '1;
    for (int i = 0; i < 20; i++) begin
      check("stall_grant", 32'(grant), 32'b0001);
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_rew_ready", 32'(env_reward_ready), 32'd0);
      check("stall_rew_valid", 32'(reward_valid), 32'd0);
      step();
    end
    action_valid = 1'b1;
    #1;
    check("stall_act_ready", 32'(action_ready), 32'd1);
    step();
    env_request = '0;
    check("stall_no_second_act", 32'(action_ready), 32'd0);
    check("stall_no_env_act", 32'(env_action_valid), 32'd0);
    check("stall_rew_data", 32'(reward_data), 32'h77);
    step();
    action_valid = 1'b0;
    clear_inputs();
    check("stall_count", 32'(episode_count), 32'd11);

    // Reset dropped in the middle of REWARD.
    env_request = 4'b0010;
    wait_busy(10);
    action_valid = 1'b1;
    env_action_ready = 4'b0010;
    step();
    clear_inputs();
    reward_ready = 1'b1;
    check("mid_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    env_reward_valid = '1;
    #1;
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rew_valid", 32'(reward_valid), 32'd0);
    check("mid_rst_rew_ready", 32'(env_reward_ready), 32'd0);
    check("mid_rst_count", 32'(episode_count), 32'd0);
    step();
    clear_inputs();
    reset = 1'b1;
    step();
    check("post_rst_busy", 32'(busy), 32'd0);

`ifdef BANDIT_ARBITER_TIMEOUT_EN
    // Env0 goes silent after its action; injected reward then env1 is served.
    env_request = 4'b0011;
    wait_busy(10);
    check("to_grant0", 32'(grant), 32'b0001);
    action_valid = 1'b1;
    env_action_ready = 4'b0001;
    step();
    action_valid = 1'b0;
    env_action_ready = '0;
    env_request = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      check("to_wait_rew_valid", 32'(reward_valid), 32'd0);
      check("to_wait_env_ready", 32'(env_reward_ready), 32'd0);
      step();
    end
    check("to_flush_valid", 32'(reward_valid), 32'd1);
    check("to_flush_data", 32'(reward_data), 32'h00);
    reward_ready = 1'b1;
    #1;
    check("to_flush_env_ready", 32'(env_reward_ready), 32'd0);
    step();
    reward_ready = 1'b0;
    check("to_count", 32'(episode_count), 32'd1);
    step();
    check("to_next_grant", 32'(grant), 32'b0010);
    clear_inputs();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
